// File: rtl/fetch_stage.sv
// In-order instruction fetch into a DEPTH-entry queue feeding IF/ID; a redirect flushes the queue and drops stale responses.
// Responses reach out_* one cycle after arrival at the earliest; stall freezes the head; issue is credit-limited.
module fetch_stage #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     DEPTH           = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [OW-1:0]   r_live;
  logic [OW-1:0]   r_stale;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [XLEN-1:0] r_q_pc    [0:DEPTH-1];
  logic [31:0]     r_q_instr [0:DEPTH-1];

  logic            w_room;
  logic            w_credit;
  logic            w_req_hs;
  logic            w_rsp_live;
  logic            w_rsp_stale;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // Live requests reserve a queue slot, so a response can always be pushed.
  assign w_room   = (32'(r_live) + 32'(r_count)) < 32'(DEPTH);
  assign w_credit = (32'(r_live) + 32'(r_stale)) < 32'(MAX_OUTSTANDING);

  assign imem_req_valid = !reset && !redirect_valid && w_room && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;

  assign w_rsp_stale   = imem_rsp_valid && (r_stale != '0);
  assign w_rsp_live    = imem_rsp_valid && (r_stale == '0);
  assign w_push        = w_rsp_live && !redirect_valid;
  assign w_pop         = out_valid && !stall && !redirect_valid;
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_q_pc[r_rd_ptr] : r_rsp_pc;
  assign out_instr = out_valid ? r_q_instr[r_rd_ptr] : NOP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_live     <= '0;
      r_stale    <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
      r_live     <= '0;
      // Every response still owed, minus the one consumed this cycle, becomes stale.
      r_stale    <= r_stale + r_live - OW'(imem_rsp_valid);
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_req_hs) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_live  <= r_live + OW'(w_req_hs) - OW'(w_rsp_live);
      r_stale <= r_stale - OW'(w_rsp_stale);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_rsp_pc;
      r_q_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (32'(r_count) <= 32'(DEPTH));
      assert ((32'(r_live) + 32'(r_stale)) <= 32'(MAX_OUTSTANDING));
      assert (!(imem_rsp_valid && (r_live == '0) && (r_stale == '0)));
      assert (!(w_push && !w_pop && (32'(r_count) == 32'(DEPTH))));
    end
  end

endmodule
